// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: ID-side fields, writeback bypass, pipeline control and EX-side results.
// master = decode/control side driving ID inputs; slave = the ID/EX register.
interface id_ex_stage_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  id_valid_i;
    logic [ADDR_WIDTH-1:0] id_rs1_i;
    logic [ADDR_WIDTH-1:0] id_rs2_i;
    logic [ADDR_WIDTH-1:0] id_rd_i;
    logic [DATA_WIDTH-1:0] id_rd1_i;
    logic [DATA_WIDTH-1:0] id_rd2_i;
    logic [DATA_WIDTH-1:0] id_imm_i;
    logic [DATA_WIDTH-1:0] id_pc_i;
    logic [CTRL_WIDTH-1:0] id_ctrl_i;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_rd_i;
    logic [DATA_WIDTH-1:0] wb_wd_i;

    logic                  ex_valid_o;
    logic [ADDR_WIDTH-1:0] ex_rs1_o;
    logic [ADDR_WIDTH-1:0] ex_rs2_o;
    logic [ADDR_WIDTH-1:0] ex_rd_o;
    logic [DATA_WIDTH-1:0] ex_op1_o;
    logic [DATA_WIDTH-1:0] ex_op2_o;
    logic [DATA_WIDTH-1:0] ex_imm_o;
    logic [DATA_WIDTH-1:0] ex_pc_o;
    logic [CTRL_WIDTH-1:0] ex_ctrl_o;
    logic                  hazard_stall_o;
    logic [CNT_WIDTH-1:0]  bubble_cnt_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rd1_i, id_rd2_i, id_imm_i, id_pc_i, id_ctrl_i,
               wb_we_i, wb_rd_i, wb_wd_i,
        input  ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_op1_o, ex_op2_o,
               ex_imm_o, ex_pc_o, ex_ctrl_o, hazard_stall_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rd1_i, id_rd2_i, id_imm_i, id_pc_i, id_ctrl_i,
               wb_we_i, wb_rd_i, wb_wd_i,
        output ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_op1_o, ex_op2_o,
               ex_imm_o, ex_pc_o, ex_ctrl_o, hazard_stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion; optional WB->ID bypass via IDEX_WB_BYPASS_EN.
// Latency: one cycle from ID inputs to ex_* outputs; hazard_stall_o is combinational.
// Backpressure: stall_i freezes all state, flush_i overrides stall; a load-use hazard inserts a bubble.
module id_ex_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 16,
    parameter int LOAD_BIT   = 3,
    parameter int CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst_n,
    id_ex_stage_reg_if.slave  bus
);
    logic                  ex_valid_q;
    logic [ADDR_WIDTH-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [DATA_WIDTH-1:0] ex_op1_q, ex_op2_q, ex_imm_q, ex_pc_q;
    logic [CTRL_WIDTH-1:0] ex_ctrl_q;
    logic [CNT_WIDTH-1:0]  bubble_cnt_q;

    logic                  ld_hazard;
    logic                  bubble_evt;
    logic [DATA_WIDTH-1:0] op1_nxt, op2_nxt;

    // Both sources are treated as read, so non-using instructions may stall needlessly.
    assign ld_hazard = ex_valid_q && ex_ctrl_q[LOAD_BIT] && (ex_rd_q != '0) && bus.id_valid_i &&
                       ((ex_rd_q == bus.id_rs1_i) || (ex_rd_q == bus.id_rs2_i)) && !bus.flush_i;

    assign bubble_evt = bus.flush_i || (!bus.stall_i && ld_hazard);

    always_comb begin
        op1_nxt = bus.id_rd1_i;
        op2_nxt = bus.id_rd2_i;
`ifdef IDEX_WB_BYPASS_EN
        if (bus.wb_we_i && (bus.wb_rd_i != '0) && (bus.wb_rd_i == bus.id_rs1_i)) op1_nxt = bus.wb_wd_i;
        if (bus.wb_we_i && (bus.wb_rd_i != '0) && (bus.wb_rd_i == bus.id_rs2_i)) op2_nxt = bus.wb_wd_i;
`endif
        if (bus.id_rs1_i == '0) op1_nxt = '0;
        if (bus.id_rs2_i == '0) op2_nxt = '0;
    end

`ifndef IDEX_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{bus.wb_we_i, bus.wb_rd_i, bus.wb_wd_i};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_imm_q   <= '0;
            ex_pc_q    <= '0;
            ex_ctrl_q  <= '0;
        end else if (bus.flush_i) begin
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_imm_q   <= '0;
            ex_pc_q    <= '0;
            ex_ctrl_q  <= '0;
        end else if (bus.stall_i) begin
            ex_valid_q <= ex_valid_q;
        end else if (ld_hazard) begin
            // Bubble: only valid/ctrl are cleared, data fields are don't-care and simply hold.
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= bus.id_valid_i;
            ex_rs1_q   <= bus.id_rs1_i;
            ex_rs2_q   <= bus.id_rs2_i;
            ex_rd_q    <= bus.id_rd_i;
            ex_op1_q   <= op1_nxt;
            ex_op2_q   <= op2_nxt;
            ex_imm_q   <= bus.id_imm_i;
            ex_pc_q    <= bus.id_pc_i;
            ex_ctrl_q  <= bus.id_valid_i ? bus.id_ctrl_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (bubble_evt && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.ex_valid_o     = ex_valid_q;
    assign bus.ex_rs1_o       = ex_rs1_q;
    assign bus.ex_rs2_o       = ex_rs2_q;
    assign bus.ex_rd_o        = ex_rd_q;
    assign bus.ex_op1_o       = ex_op1_q;
    assign bus.ex_op2_o       = ex_op2_q;
    assign bus.ex_imm_o       = ex_imm_q;
    assign bus.ex_pc_o        = ex_pc_q;
    assign bus.ex_ctrl_o      = ex_ctrl_q;
    assign bus.hazard_stall_o = ld_hazard;
    assign bus.bubble_cnt_o   = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver queues hand-computed expectations, monitor checks each cycle.
module tb_id_ex_stage_reg;
    localparam int DW = 32, AW = 5, CW = 16, CNTW = 8;

`ifdef IDEX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(CNTW)) bus();

    id_ex_stage_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .LOAD_BIT(3), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic st, fl, v;
        logic [4:0] rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc;
        logic [15:0] ctrl;
        logic we;
        logic [4:0] wrd;
        logic [31:0] wd;
    } in_t;

    typedef struct {
        string name;
        logic hz, full, v;
        logic [4:0] rs1, rs2, rd;
        logic [31:0] op1, op2, imm, pc;
        logic [15:0] ctrl;
        logic [7:0] cnt;
    } exp_t;

    int checks = 0;
    int failures = 0;
    exp_t q[$];
    exp_t pend;
    bit pend_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk_in(input logic st, fl, v, input logic [4:0] rs1, rs2, rd,
                                  input logic [31:0] rd1, rd2, imm, pc, input logic [15:0] ctrl,
                                  input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        in_t i;
        i.st = st; i.fl = fl; i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.rd1 = rd1; i.rd2 = rd2; i.imm = imm; i.pc = pc; i.ctrl = ctrl;
        i.we = we; i.wrd = wrd; i.wd = wd;
        return i;
    endfunction

    function automatic exp_t mk_exp(input string nm, input logic hz, full, v, input logic [4:0] rs1, rs2, rd,
                                    input logic [31:0] op1, op2, imm, pc, input logic [15:0] ctrl,
                                    input logic [7:0] cnt);
        exp_t e;
        e.name = nm; e.hz = hz; e.full = full; e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.op1 = op1; e.op2 = op2; e.imm = imm; e.pc = pc; e.ctrl = ctrl; e.cnt = cnt;
        return e;
    endfunction

    task automatic drive(input in_t i);
        bus.stall_i = i.st; bus.flush_i = i.fl; bus.id_valid_i = i.v;
        bus.id_rs1_i = i.rs1; bus.id_rs2_i = i.rs2; bus.id_rd_i = i.rd;
        bus.id_rd1_i = i.rd1; bus.id_rd2_i = i.rd2; bus.id_imm_i = i.imm; bus.id_pc_i = i.pc;
        bus.id_ctrl_i = i.ctrl; bus.wb_we_i = i.we; bus.wb_rd_i = i.wrd; bus.wb_wd_i = i.wd;
    endtask

    // One cycle: inputs for the coming edge plus the expectation for that edge.
    task automatic cyc(input in_t i, input exp_t e);
        drive(i);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input exp_t e);
        chk({e.name, ".valid"}, {31'b0, bus.ex_valid_o}, {31'b0, e.v});
        chk({e.name, ".ctrl"}, {16'b0, bus.ex_ctrl_o}, {16'b0, e.ctrl});
        chk({e.name, ".cnt"}, {24'b0, bus.bubble_cnt_o}, {24'b0, e.cnt});
        if (e.full) begin
            chk({e.name, ".rs1"}, {27'b0, bus.ex_rs1_o}, {27'b0, e.rs1});
            chk({e.name, ".rs2"}, {27'b0, bus.ex_rs2_o}, {27'b0, e.rs2});
            chk({e.name, ".rd"}, {27'b0, bus.ex_rd_o}, {27'b0, e.rd});
            chk({e.name, ".op1"}, bus.ex_op1_o, e.op1);
            chk({e.name, ".op2"}, bus.ex_op2_o, e.op2);
            chk({e.name, ".imm"}, bus.ex_imm_o, e.imm);
            chk({e.name, ".pc"}, bus.ex_pc_o, e.pc);
        end
    endtask

    task automatic check_zero(input string nm);
        check_state(mk_exp(nm, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0, 8'd0));
    endtask

    task automatic drain();
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Monitor: state after the edge for the previous record, hazard for the newly applied inputs.
    always @(negedge clk) begin
        if (pend_v) begin
            check_state(pend);
            pend_v = 1'b0;
        end
        if (q.size() > 0) begin
            pend = q.pop_front();
            pend_v = 1'b1;
            chk({pend.name, ".hz"}, {31'b0, bus.hazard_stall_o}, {31'b0, pend.hz});
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        in_t idle;
        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        @(posedge clk); #1;
        check_zero("reset_init");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Build up non-zero state, then reset asynchronously mid-cycle.
        cyc(mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            mk_exp("pre_flush", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 8'd1));
        cyc(mk_in(0, 0, 1, 1, 2, 3, 32'h1234, 0, 0, 32'h80, 0, 0, 0, 0),
            mk_exp("pre_load", 0, 1, 1, 1, 2, 3, 32'h1234, 0, 0, 32'h80, 16'h0, 8'd1));
        drain();
        drive(mk_in(0, 0, 1, 1, 2, 3, 32'h5555, 0, 0, 32'h90, 16'h1, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");
        @(posedge clk); #1;
        check_zero("rst_held");
        @(negedge clk); rst_n = 1'b1;
        #1 check_zero("rst_release");
        @(posedge clk); #1;
        check_state(mk_exp("rst_first_edge", 0, 1, 1, 1, 2, 3, 32'h5555, 0, 0, 32'h90, 16'h1, 8'd0));

        cyc(mk_in(0, 0, 1, 5, 6, 9, 32'hA, 32'hB, 32'h10, 32'h100, 16'h1, 0, 0, 0),
            mk_exp("normal", 0, 1, 1, 5, 6, 9, 32'hA, 32'hB, 32'h10, 32'h100, 16'h1, 8'd0));
        cyc(mk_in(0, 0, 1, 1, 2, 7, 32'h11, 32'h22, 32'h4, 32'h104, 16'h8, 0, 0, 0),
            mk_exp("load_rd7", 0, 1, 1, 1, 2, 7, 32'h11, 32'h22, 32'h4, 32'h104, 16'h8, 8'd0));
        cyc(mk_in(0, 0, 1, 3, 7, 8, 32'h33, 32'h77, 32'h8, 32'h108, 16'h2, 0, 0, 0),
            mk_exp("hazard_bubble", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 8'd1));
        cyc(mk_in(0, 0, 1, 3, 7, 8, 32'h33, 32'h77, 32'h8, 32'h108, 16'h2, 0, 0, 0),
            mk_exp("hazard_retry", 0, 1, 1, 3, 7, 8, 32'h33, 32'h77, 32'h8, 32'h108, 16'h2, 8'd1));
        cyc(mk_in(0, 0, 1, 0, 4, 1, 32'hFFFF, 32'h44, 0, 32'h10C, 16'h8, 0, 0, 0),
            mk_exp("rs1_x0", 0, 1, 1, 0, 4, 1, 0, 32'h44, 0, 32'h10C, 16'h8, 8'd1));
        for (int k = 0; k < 3; k++)
            cyc(mk_in(1, 0, 1, 1, 0, 2, 32'h55, 0, 0, 32'h110, 16'h1, 0, 0, 0),
                mk_exp("stall_hold", 1, 1, 1, 0, 4, 1, 0, 32'h44, 0, 32'h10C, 16'h8, 8'd1));
        cyc(mk_in(1, 1, 1, 1, 0, 2, 32'h55, 0, 0, 32'h110, 16'h1, 0, 0, 0),
            mk_exp("stall_flush", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 8'd2));
        cyc(mk_in(0, 0, 0, 2, 3, 4, 32'h12, 32'h13, 32'h20, 32'h110, 16'hFF, 0, 0, 0),
            mk_exp("invalid_slot", 0, 1, 0, 2, 3, 4, 32'h12, 32'h13, 32'h20, 32'h110, 16'h0, 8'd2));
        cyc(mk_in(0, 0, 1, 0, 0, 0, 32'h1, 32'h2, 0, 32'h114, 16'h8, 0, 0, 0),
            mk_exp("load_rd0", 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h114, 16'h8, 8'd2));
        cyc(mk_in(0, 0, 1, 0, 0, 3, 0, 0, 0, 32'h118, 16'h0, 0, 0, 0),
            mk_exp("no_hz_rd0", 0, 1, 1, 0, 0, 3, 0, 0, 0, 32'h118, 16'h0, 8'd2));
        cyc(mk_in(0, 0, 1, 5, 5, 2, 32'h0, 32'h22, 0, 32'h11C, 16'h0, 1, 5, 32'hDEAD),
            mk_exp("bypass", 0, 1, 1, 5, 5, 2, BYP ? 32'hDEAD : 32'h0, BYP ? 32'hDEAD : 32'h22,
                   0, 32'h11C, 16'h0, 8'd2));
        cyc(mk_in(0, 0, 1, 0, 6, 2, 32'h99, 32'h66, 0, 32'h120, 16'h0, 1, 0, 32'hBEEF),
            mk_exp("bypass_wb_x0", 0, 1, 1, 0, 6, 2, 0, 32'h66, 0, 32'h120, 16'h0, 8'd2));
        cyc(mk_in(0, 0, 1, 6, 6, 2, 32'h61, 32'h66, 0, 32'h124, 16'h0, 0, 6, 32'hBEEF),
            mk_exp("bypass_we0", 0, 1, 1, 6, 6, 2, 32'h61, 32'h66, 0, 32'h124, 16'h0, 8'd2));
        cyc(mk_in(0, 0, 1, 1, 2, 7, 32'h10, 32'h20, 0, 32'h128, 16'h8, 0, 0, 0),
            mk_exp("load_rd7b", 0, 1, 1, 1, 2, 7, 32'h10, 32'h20, 0, 32'h128, 16'h8, 8'd2));
        cyc(mk_in(0, 1, 1, 7, 0, 4, 32'h70, 0, 0, 32'h12C, 16'h2, 0, 0, 0),
            mk_exp("flush_hz_once", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 8'd3));

        // Counter saturation: 255 more flushes drive it past all-ones.
        for (int k = 0; k < 255; k++)
            cyc(mk_in(0, 1, 1, 7, 7, 1, 0, 0, 0, 32'h200, 16'h8, 0, 0, 0),
                mk_exp("sat_flush", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,
                       (4 + k > 255) ? 8'd255 : 8'(4 + k)));
        cyc(mk_in(0, 0, 1, 1, 2, 9, 32'h1, 32'h2, 0, 32'h300, 16'h8, 0, 0, 0),
            mk_exp("sat_load", 0, 1, 1, 1, 2, 9, 32'h1, 32'h2, 0, 32'h300, 16'h8, 8'd255));
        cyc(mk_in(0, 0, 1, 9, 3, 4, 32'h5, 32'h6, 0, 32'h304, 16'h0, 0, 0, 0),
            mk_exp("sat_bubble", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 8'd255));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
